ps2_mouse_packet_rx: RTL and testbench



---
 rtl/ps2_mouse_packet_rx.sv | 179 +++++++++++++++++
 tb/tb_ps2_mouse_packet_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: sync/filter PS2Clk+PS2Data, deserialise 11-bit frames, assemble 3-byte packets.
// Latency: packet outputs update 1 cycle after the final stop-bit fall event (2 + FILTER_LEN cycles after the PS2Clk edge).
// Backpressure: none; outputs hold until the next packet, packet_valid/frame_err are single-cycle strobes.
module ps2_mouse_packet_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PS2Clk,
    input  logic        PS2Data,
    output logic [8:0]  dx,
    output logic [8:0]  dy,
    output logic        left,
    output logic        right,
    output logic        middle,
    output logic        overflow,
    output logic        packet_valid,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          fclk;
    logic [FW-1:0] flt_cnt;
    logic          fall_evt;

    state_t        state, state_nxt;
    logic [7:0]    shift_dat;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;

    logic          tmo_hit, frame_good, byte_ok, frame_bad;

    logic [1:0]    pkt_idx;
    logic [7:0]    hdr;
    logic [7:0]    x_byte;

    // Two-flop synchronisers; idle level of both lines is high
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2Clk;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2Data;
            dat_s2 <= dat_s1;
        end
    end

    // Clock filter: fclk follows clk_s2 only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            fclk    <= 1'b1;
            flt_cnt <= '0;
        end else if (clk_s2 == fclk) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FLT_LAST) begin
            fclk    <= clk_s2;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    // Bit event is the cycle in which fclk is about to drop; data is sampled in that same cycle
    assign fall_evt = fclk & ~clk_s2 & (flt_cnt == FLT_LAST);

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Frame FSM next-state; a timeout only fires when no bit event competes with it
    always_comb begin
        state_nxt = state;
        if (tmo_hit) begin
            state_nxt = S_IDLE;
        end else if (fall_evt) begin
            case (state)
                S_IDLE:   state_nxt = dat_s2 ? S_IDLE : S_DATA;
                S_DATA:   state_nxt = (bit_cnt == 3'd7) ? S_PARITY : S_DATA;
                S_PARITY: state_nxt = S_STOP;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame FSM outputs: byte acceptance, frame errors and timeout detection
    always_comb begin
        tmo_hit    = (state != S_IDLE) && !fall_evt && (tmo_cnt == TMO_LAST);
        frame_good = (^{shift_dat, par_bit}) & dat_s2;
        byte_ok    = fall_evt && (state == S_STOP) && frame_good;
        frame_bad  = (fall_evt && (state == S_STOP) && !frame_good) || tmo_hit;
    end

    // Frame datapath: LSB-first shift, bit count, parity capture, inactivity counter
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_dat <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (fall_evt || state == S_IDLE) tmo_cnt <= '0;
            else                             tmo_cnt <= tmo_cnt + 1'b1;
            if (fall_evt) begin
                case (state)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shift_dat <= {dat_s2, shift_dat[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    S_PARITY: par_bit <= dat_s2;
                    default:  ;
                endcase
            end
        end
    end

    // Packet assembler: header needs bit3 set to resync; any frame error restarts the packet
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_idx      <= '0;
            hdr          <= '0;
            x_byte       <= '0;
            dx           <= '0;
            dy           <= '0;
            left         <= 1'b0;
            right        <= 1'b0;
            middle       <= 1'b0;
            overflow     <= 1'b0;
            packet_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            frame_err    <= frame_bad;
            if (frame_bad) begin
                pkt_idx <= '0;
            end else if (byte_ok) begin
                case (pkt_idx)
                    2'd0: begin
                        if (shift_dat[3]) begin
                            hdr     <= shift_dat;
                            pkt_idx <= 2'd1;
                        end
                    end
                    2'd1: begin
                        x_byte  <= shift_dat;
                        pkt_idx <= 2'd2;
                    end
                    2'd2: begin
                        dx           <= {hdr[4], x_byte};
                        dy           <= {hdr[5], shift_dat};
                        left         <= hdr[0];
                        right        <= hdr[1];
                        middle       <= hdr[2];
                        overflow     <= hdr[6] | hdr[7];
                        packet_valid <= 1'b1;
                        pkt_idx      <= 2'd0;
                    end
                    default: pkt_idx <= 2'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Bench for ps2_mouse_packet_rx: drives PS/2 frames, scoreboards decoded packets and frame errors.
// Latency: packet expectations are popped whenever packet_valid is seen.
// Backpressure: not applicable.
module tb_ps2_mouse_packet_rx;

    localparam int FLT  = 4;
    localparam int TMO  = 200;
    localparam int HALF = 10;

    typedef struct {
        logic [8:0] dx;
        logic [8:0] dy;
        logic       l;
        logic       r;
        logic       m;
        logic       ovf;
    } pkt_t;

    logic       clk;
    logic       reset;
    logic       PS2Clk;
    logic       PS2Data;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       left;
    logic       right;
    logic       middle;
    logic       overflow;
    logic       packet_valid;
    logic       frame_err;

    pkt_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    int   err_cnt = 0;
    int   pkt_cnt = 0;
    int   err_cyc = -1;

    ps2_mouse_packet_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
        .dx(dx), .dy(dy), .left(left), .right(right), .middle(middle),
        .overflow(overflow), .packet_valid(packet_valid), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs === expv) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    // Output monitor: pops the scoreboard on every packet strobe
    always @(negedge clk) begin
        if (!reset) begin
            if (packet_valid || frame_err)
                chk("strobe_exclusive", {31'd0, packet_valid & frame_err}, 32'd0);
            if (frame_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (packet_valid) begin
                pkt_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_packet", 32'd1, 32'd0);
                end else begin
                    pkt_t e;
                    e = exp_q.pop_front();
                    chk("dx", {23'd0, dx}, {23'd0, e.dx});
                    chk("dy", {23'd0, dy}, {23'd0, e.dy});
                    chk("left", {31'd0, left}, {31'd0, e.l});
                    chk("right", {31'd0, right}, {31'd0, e.r});
                    chk("middle", {31'd0, middle}, {31'd0, e.m});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                end
            end
        end
    end

    task automatic push_exp(input logic [8:0] edx, input logic [8:0] edy,
                            input logic el, input logic er, input logic em, input logic eo);
        pkt_t p;
        p.dx = edx; p.dy = edy; p.l = el; p.r = er; p.m = em; p.ovf = eo;
        exp_q.push_back(p);
    endtask

    // One device-to-host bit: data set up while clock high, then a clean low pulse
    task automatic send_bit(input logic b, output int fall_cyc);
        PS2Data = b;
        repeat (HALF) @(negedge clk);
        PS2Clk   = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        PS2Clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        int fc;
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0, fc);
        for (int i = 0; i < 8; i++) send_bit(b[i], fc);
        send_bit(par, fc);
        send_bit(1'b1, fc);
        PS2Data = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        int base;
        int errs_before;
        int pkts_before;
        bit quiet;

        reset   = 1'b1;
        PS2Clk  = 1'b1;
        PS2Data = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_dx", {23'd0, dx}, 32'd0);
        chk("rst_dy", {23'd0, dy}, 32'd0);
        chk("rst_btn", {29'd0, left, right, middle}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_pv", {31'd0, packet_valid}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);

        // Basic packet with negative Y
        push_exp(9'h005, 9'h1FB, 1'b1, 1'b0, 1'b0, 1'b0);
        send_packet(8'h29, 8'h05, 8'hFB);
        chk("t1_pkts", pkt_cnt, 32'd1);
        chk("t1_errs", err_cnt, 32'd0);

        // Bad parity byte raises frame_err only, next packet decodes cleanly
        send_byte(8'h08, 1'b1);
        chk("t2_err", err_cnt, 32'd1);
        chk("t2_nopkt", pkt_cnt, 32'd1);
        push_exp(9'h001, 9'h002, 1'b0, 1'b1, 1'b0, 1'b0);
        send_packet(8'h0A, 8'h01, 8'h02);
        chk("t2_pkts", pkt_cnt, 32'd2);

        // Header without bit3 is discarded silently
        send_byte(8'h00, 1'b0);
        push_exp(9'h003, 9'h004, 1'b0, 1'b0, 1'b0, 1'b0);
        send_packet(8'h08, 8'h03, 8'h04);
        chk("t3_pkts", pkt_cnt, 32'd3);
        chk("t3_errs", err_cnt, 32'd1);

        // Mid-frame timeout: frame_err lands 2 sync + FLT filter + TMO cycles after the drive
        send_bit(1'b0, fc);
        for (int i = 0; i < 4; i++) send_bit(1'b1, fc);
        PS2Data = 1'b1;
        base = fc;
        for (int i = 0; i < 2 * TMO && err_cnt == 1; i++) @(negedge clk);
        chk("t4_err", err_cnt, 32'd2);
        chk("t4_err_cycle", err_cyc, base + 2 + FLT + TMO);
        repeat (10) @(negedge clk);
        push_exp(9'h010, 9'h020, 1'b0, 1'b0, 1'b0, 1'b0);
        send_packet(8'h08, 8'h10, 8'h20);
        chk("t4_pkts", pkt_cnt, 32'd4);

        // Reset mid-packet discards the partial packet and clears outputs
        send_byte(8'h08, 1'b0);
        send_byte(8'h11, 1'b0);
        do_reset();
        chk("t5_rst_dx", {23'd0, dx}, 32'd0);
        chk("t5_rst_btn", {29'd0, left, right, middle}, 32'd0);
        push_exp(9'h0FF, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1);
        send_packet(8'hC9, 8'hFF, 8'h00);
        chk("t5_pkts", pkt_cnt, 32'd5);

        // Short PS2Clk glitch with data low must not start a frame
        errs_before = err_cnt;
        pkts_before = pkt_cnt;
        PS2Data = 1'b0;
        repeat (HALF) @(negedge clk);
        PS2Clk = 1'b0;
        repeat (2) @(negedge clk);
        PS2Clk = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (packet_valid || frame_err) quiet = 1'b0;
        end
        PS2Data = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_quiet", {31'd0, quiet}, 32'd1);
        chk("t6_hold_dx", {23'd0, dx}, 32'h0FF);
        chk("t6_hold_ovf", {31'd0, overflow}, 32'd1);
        push_exp(9'h107, 9'h009, 1'b0, 1'b0, 1'b0, 1'b0);
        send_packet(8'h18, 8'h07, 8'h09);
        chk("t6_pkts", pkt_cnt, pkts_before + 1);
        chk("t6_errs", err_cnt, errs_before);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
